timer_counter: RTL and testbench

- Memory-mapped countdown timer on the system bridge.
- Its IRQ output drives one bit of the HWInt bus into the coprocessor-0 interrupt logic; this is the interrupt source directly upstream of the exception/interrupt controller.
- Software programs it with sw/lw through the bridge.
- It has one-shot and auto-reload modes, a 4-state FSM, and a maskable interrupt.

---
 rtl/timer_counter.sv | 115 +++++++++++
 tb/tb_timer_counter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// Memory-mapped 32-bit countdown timer with one-shot / auto-reload modes and a
// maskable interrupt that feeds one HWInt line of the coprocessor-0 logic.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic        irq_flag;

  logic        enable;
  logic [1:0]  mode;
  logic        irq_mask;
  logic [1:0]  reg_sel;

  logic unused_addr;
  assign unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign enable   = ctrl[0];
  assign mode     = ctrl[2:1];
  assign irq_mask = ctrl[3];
  assign reg_sel  = Addr[3:2];

  // Saturating decrement: the counter bottoms out at zero and never wraps.
  function automatic logic [31:0] dec_sat(input logic [31:0] value);
    dec_sat = (value > 32'd1) ? value - 32'd1 : 32'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'd0;
    end else if (WE) begin
      if (reg_sel == REG_CTRL) ctrl <= Din[3:0];
    end else if (state == INT && mode != MODE_RELOAD) begin
      ctrl[0] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (WE && reg_sel == REG_PRESET) begin
      preset <= Din;
    end
  end

  // Any bus write freezes the FSM for that cycle, whatever register it targets.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else if (!WE) begin
      case (state)
        IDLE: begin
          if (enable) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            count <= dec_sat(count);
            if (count <= 32'd1) begin
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
        end
        default: begin
          if (mode == MODE_RELOAD) irq_flag <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (reg_sel)
      REG_CTRL:   Dout = {28'd0, ctrl};
      REG_PRESET: Dout = preset;
      REG_COUNT:  Dout = count;
      default:    Dout = 32'd0;
    endcase
  end

  assign IRQ = irq_mask & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: register access, one-shot and auto-reload
// timing, interrupt masking, disable mid-count and reset override.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    Addr = a;
    #1;
    chk(tag, Dout, exp);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    chk(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One bus write; the rising edge inside this call is the write edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
    Din  = 32'd0;
  endtask

  // Auto-reload with PRESET=3: expected COUNT k edges after an IDLE-state reference point.
  function automatic logic [31:0] m01_count(input int k);
    case (k % 6)
      2:       m01_count = 32'd3;
      3:       m01_count = 32'd2;
      4:       m01_count = 32'd1;
      default: m01_count = 32'd0;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 32'd0;
    Din   = 32'd0;
    tick();
    tick();
    reset = 1'b0;

    rd(32'h0, 32'd0, "rst_ctrl");
    rd(32'h4, 32'd0, "rst_preset");
    rd(32'h8, 32'd0, "rst_count");
    rd(32'hC, 32'd0, "rst_reserved");
    chk_irq(1'b0, "rst_irq");

    // One-shot, PRESET=5
    wr(32'h4, 32'd5);
    rd(32'h4, 32'd5, "preset_rb");
    wr(32'h0, 32'h9);
    tick();
    rd(32'h8, 32'd0, "os_load_cycle");
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(32'h8, 32'(5 - i), "os_count");
      chk_irq(1'b0, "os_irq_low");
    end
    tick();
    rd(32'h8, 32'd0, "os_count_zero");
    chk_irq(1'b1, "os_irq_rise");
    tick();
    rd(32'h0, 32'h8, "os_ctrl_cleared");
    chk_irq(1'b1, "os_irq_held");
    tick();
    tick();
    chk_irq(1'b1, "os_irq_sticky");
    rd(32'h8, 32'd0, "os_count_idle");

    // Auto-reload, PRESET=3, IM=1
    wr(32'h4, 32'd3);
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 17; k++) begin
      tick();
      rd(32'h8, m01_count(k), "ar_count");
      chk_irq((k % 6) == 5, "ar_irq");
    end

    // Masked auto-reload; write lands while in INT with the flag still set
    wr(32'h0, 32'h3);
    chk_irq(1'b0, "mask_immediate");
    for (int j = 1; j <= 13; j++) begin
      tick();
      rd(32'h8, m01_count(j - 1), "mask_count");
      chk_irq(1'b0, "mask_irq");
    end
    wr(32'h0, 32'hB);
    for (int k = 1; k <= 12; k++) begin
      tick();
      rd(32'h8, m01_count(k), "unmask_count");
      chk_irq((k % 6) == 5, "unmask_irq");
    end

    // Disable mid-count; upper CTRL bits are not stored
    wr(32'h0, 32'hFFFF_FFF0);
    rd(32'h0, 32'd0, "ctrl_upper_bits");
    wr(32'h4, 32'd10);
    wr(32'h0, 32'h9);
    tick();
    for (int i = 2; i <= 7; i++) begin
      tick();
      rd(32'h8, 32'(12 - i), "dis_count");
    end
    wr(32'h0, 32'h0);
    rd(32'h8, 32'd5, "dis_hold_cycle");
    tick();
    rd(32'h8, 32'd5, "dis_frozen");
    tick();
    rd(32'h8, 32'd5, "dis_still_frozen");
    chk_irq(1'b0, "dis_irq");
    rd(32'h0, 32'd0, "dis_ctrl");

    // Re-enable with a new PRESET
    wr(32'h4, 32'd2);
    wr(32'h0, 32'h9);
    tick();
    rd(32'h8, 32'd5, "re_load_cycle");
    tick();
    rd(32'h8, 32'd2, "re_count2");
    tick();
    rd(32'h8, 32'd1, "re_count1");
    chk_irq(1'b0, "re_irq_low");
    tick();
    rd(32'h8, 32'd0, "re_count0");
    chk_irq(1'b1, "re_irq_high");

    // Reset in INT, with a competing PRESET write
    Addr  = 32'h4;
    Din   = 32'hDEAD;
    WE    = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    WE    = 1'b0;
    Din   = 32'd0;
    chk_irq(1'b0, "rst2_irq");
    rd(32'h0, 32'd0, "rst2_ctrl");
    rd(32'h4, 32'd0, "rst2_preset");
    rd(32'h8, 32'd0, "rst2_count");
    rd(32'hC, 32'd0, "rst2_reserved");

    wr(32'h8, 32'h1234);
    rd(32'h8, 32'd0, "count_readonly");
    wr(32'hC, 32'h55);
    rd(32'hC, 32'd0, "reserved_ignored");
    rd(32'h0, 32'd0, "ctrl_untouched");
    tick();
    tick();
    rd(32'h8, 32'd0, "count_stays_idle");
    chk_irq(1'b0, "final_irq");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
